// File: rtl/output_drain_pkg.sv
// Shared widths, burst limit and FSM encoding for the output_buffer read-side drain.
package output_drain_pkg;
  localparam int OD_ADDR_W   = 13;
  localparam int OD_DATA_W   = 128;
  localparam int OD_MAX_ROWS = 32;
  localparam int OD_LEN_W    = $clog2(OD_MAX_ROWS) + 1;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WAIT,
    FIN
  } state_e;
endpackage

// File: rtl/output_drain_fifo.sv
// drain_fifo: 2-entry shift FIFO with registered head; a push on the cycle a pop empties it lands in the head.
// Push is never refused; the producer must gate pushes on count so the FIFO cannot overflow.
module drain_fifo #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  output logic         pop_vld,
  input  logic         pop_rdy,
  output logic [W-1:0] pop_dat,
  output logic [1:0]   count
);
  logic [W-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         pop;

  assign pop     = pop_rdy && (cnt_q != 2'd0);
  assign pop_vld = (cnt_q != 2'd0);
  assign pop_dat = head_q;
  assign count   = cnt_q;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    unique case ({push_vld, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = push_dat;
        else               tail_d = push_dat;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_d = push_dat;
        end else begin
          head_d = tail_q;
          tail_d = push_dat;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/output_drain.sv
// Drains a burst of rows from output_buffer into a valid/ready stream; first beat 2 cycles after start.
// Reads are credit-gated so captured plus in-flight rows never exceed the 2-entry FIFO under backpressure.
module output_drain
  import output_drain_pkg::*;
#(
  parameter int ADDR_W = OD_ADDR_W,
  parameter int DATA_W = OD_DATA_W,
  parameter int LEN_W  = OD_LEN_W
) (
  input  logic              CLK,
  input  logic              RETN,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  num_rows,
  output logic              busy,
  output logic              done,
  output logic              buf_CEN,
  output logic              buf_WEN,
  output logic [ADDR_W-1:0] buf_A,
  input  logic [DATA_W-1:0] buf_Q,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  issued_q, issued_d;
  logic [LEN_W-1:0]  beats_q, beats_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        fifo_cnt;
  logic              pop, issue, last_issue;

  drain_fifo #(.W(DATA_W)) u_fifo (
    .clk      (CLK),
    .rst_n    (RETN),
    .push_vld (inflight_q),
    .push_dat (buf_Q),
    .pop_vld  (m_valid),
    .pop_rdy  (m_ready),
    .pop_dat  (m_data),
    .count    (fifo_cnt)
  );

  // A beat leaving this cycle frees a slot for the read issued this cycle.
  assign pop        = m_valid && m_ready;
  assign issue      = (state_q == READ) &&
                      (({1'b0, fifo_cnt} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
  assign last_issue = (issued_q == (len_q - LEN_W'(1)));

  assign m_last  = m_valid && (beats_q == (len_q - LEN_W'(1)));
  assign buf_CEN = !issue;
  assign buf_WEN = 1'b1;
  assign buf_A   = addr_q;
  assign busy    = (state_q == READ) || (state_q == WAIT);
  assign done    = (state_q == FIN);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    issued_d   = issued_q;
    beats_d    = pop ? (beats_q + LEN_W'(1)) : beats_q;
    inflight_d = issue;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d   = base_addr;
          len_d    = num_rows;
          issued_d = '0;
          beats_d  = '0;
          state_d  = (num_rows == '0) ? FIN : READ;
        end
      end
      READ: begin
        if (issue) begin
          addr_d   = addr_q + ADDR_W'(1);
          issued_d = issued_q + LEN_W'(1);
          if (last_issue) state_d = WAIT;
        end
      end
      WAIT: begin
        if (pop && m_last) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RETN) begin
    if (!RETN) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      beats_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      beats_q    <= beats_d;
      inflight_q <= inflight_d;
    end
  end
endmodule

// File: tb/tb_output_drain.sv
// Random/directed bench for output_drain with a buffer model and a queue-based reference of bursts.
module tb_output_drain;
  import output_drain_pkg::*;
  localparam int AW = OD_ADDR_W;
  localparam int DW = OD_DATA_W;
  localparam int LW = OD_LEN_W;

  logic          CLK = 1'b0;
  logic          RETN = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] num_rows = '0;
  logic          m_ready = 1'b0;
  logic          busy, done, buf_CEN, buf_WEN, m_valid, m_last;
  logic [AW-1:0] buf_A;
  logic [DW-1:0] buf_Q, m_data;

  output_drain dut (
    .CLK(CLK), .RETN(RETN), .start(start), .base_addr(base_addr), .num_rows(num_rows),
    .busy(busy), .done(done), .buf_CEN(buf_CEN), .buf_WEN(buf_WEN), .buf_A(buf_A),
    .buf_Q(buf_Q), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
  );

  always #5 CLK = ~CLK;

  // Buffer model: registered read, zeros when not enabled.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] buf_q_r = '0;
  always @(posedge CLK) buf_q_r <= (!buf_CEN) ? mem[buf_A] : '0;
  assign buf_Q = buf_q_r;

  typedef struct packed {
    logic [DW-1:0] dat;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  logic [AW-1:0] exp_addr[$];
  int checks = 0, errors = 0;
  int phase = 0;
  int done_cnt = 0, hs_cnt = 0, rd_burst = 0, hs_burst = 0;
  int rdy_mode = 0, cyc = 0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] stall_dat = '0;
  logic          last_hs;
  beat_t         b;

  function automatic void chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endfunction

  always @(posedge CLK) begin
    #1;
    cyc++;
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = (cyc % 3 == 0);
      default: m_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor / reference: a burst of N rows from base B yields reads B..B+N-1 (mod 2^AW),
  // beats mem[B+k] in order with last on k=N-1, then one done cycle; start only counts when idle.
  always @(negedge CLK) begin
    if (!RETN) begin
      exp_q.delete();
      exp_addr.delete();
      phase = 0;
      stall_prev = 1'b0;
    end else begin
      chk("busy", busy, phase == 1);
      chk("done", done, phase == 2);
      chk("buf_WEN", buf_WEN, 1);
      if (!m_valid) chk("m_last_idle", m_last, 0);
      if (stall_prev) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, stall_dat);
      end
      last_hs = 1'b0;
      if (m_valid && m_ready) begin
        hs_burst++;
        hs_cnt++;
        chk("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          b = exp_q.pop_front();
          chk("m_data", m_data, b.dat);
          chk("m_last", m_last, b.last);
          last_hs = b.last;
        end
      end
      if (!buf_CEN) begin
        rd_burst++;
        chk("read_expected", exp_addr.size() > 0, 1);
        if (exp_addr.size() > 0) chk("buf_A", buf_A, exp_addr.pop_front());
        chk("outstanding_le2", (rd_burst - hs_burst) <= 2, 1);
      end
      stall_prev = m_valid && !m_ready;
      stall_dat  = m_data;
      if (done) done_cnt++;
      case (phase)
        0: if (start) begin
          rd_burst = 0;
          hs_burst = 0;
          for (int k = 0; k < int'(num_rows); k++) begin
            exp_addr.push_back(AW'(int'(base_addr) + k));
            exp_q.push_back('{dat: mem[AW'(int'(base_addr) + k)], last: (k == int'(num_rows) - 1)});
          end
          phase = (num_rows == '0) ? 2 : 1;
        end
        1: if (last_hs) phase = 2;
        default: phase = 0;
      endcase
    end
  end

  task automatic issue_start(input logic [AW-1:0] b_a, input int len);
    start = 1'b1;
    base_addr = b_a;
    num_rows = LW'(len);
    @(posedge CLK);
    #1;
    start = 1'b0;
    base_addr = AW'($urandom);
    num_rows = LW'($urandom_range(0, 32));
  endtask

  task automatic wait_done(input int d0, input int budget, output int n);
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge CLK);
      #1;
      n++;
    end
    chk("done_seen", done_cnt != d0, 1);
    chk("beats_left", exp_q.size(), 0);
    chk("reads_left", exp_addr.size(), 0);
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_outputs();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_CEN", buf_CEN, 1);
    chk("rst_WEN", buf_WEN, 1);
    chk("rst_A", buf_A, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d0, h0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = {$urandom, $urandom, $urandom, 32'(i)};
    #1;
    check_reset_outputs();
    repeat (3) @(posedge CLK);
    #2 RETN = 1'b1;
    @(posedge CLK);
    #1;

    // Basic burst: no bubbles, done on cycle N+2 after the sampling edge.
    rdy_mode = 0;
    d0 = done_cnt;
    issue_start(13'h0000, 4);
    wait_done(d0, 200, n);
    chk("basic_latency", n, 7);

    // Backpressure with ready 1,0,0 repeating.
    rdy_mode = 1;
    d0 = done_cnt;
    issue_start(13'h0040, 8);
    wait_done(d0, 400, n);

    // Address wrap.
    rdy_mode = 0;
    d0 = done_cnt;
    issue_start(13'h1FFE, 4);
    wait_done(d0, 200, n);

    // Zero length: done right after the sampling edge.
    d0 = done_cnt;
    issue_start(13'h0123, 0);
    wait_done(d0, 50, n);
    chk("zero_latency", n, 1);

    // Reset after the third beat of a 16-row burst.
    h0 = hs_cnt;
    d0 = done_cnt;
    issue_start(13'h0200, 16);
    n = 0;
    while (hs_cnt < h0 + 3 && n < 200) begin
      @(negedge CLK);
      #1;
      n++;
    end
    chk("three_beats_seen", hs_cnt >= h0 + 3, 1);
    @(posedge CLK);
    #2 RETN = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge CLK);
    #2 RETN = 1'b1;
    @(posedge CLK);
    #1;
    chk("no_done_on_reset", done_cnt, d0);
    d0 = done_cnt;
    issue_start(13'h0300, 5);
    wait_done(d0, 200, n);

    // Start while busy is ignored.
    rdy_mode = 2;
    d0 = done_cnt;
    h0 = hs_cnt;
    issue_start(13'h0A00, 32);
    repeat (8) @(posedge CLK);
    #1;
    issue_start(13'h0B00, 7);
    wait_done(d0, 800, n);
    chk("busy_start_beats", hs_cnt - h0, 32);

    // Random bursts.
    for (int t = 0; t < 8; t++) begin
      rdy_mode = 2;
      d0 = done_cnt;
      issue_start(AW'($urandom), $urandom_range(0, 32));
      wait_done(d0, 800, n);
      repeat ($urandom_range(0, 3)) @(posedge CLK);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
